glyph_column_sequencer: RTL and testbench
=========================================

// Module: glyph_column_sequencer
// PURPOSE
//  Sequences the 5x7 character ROM for the LED-matrix text path. Buffers ASCII codes from the
//  CPU-side register interface in a small FIFO and drives the ROM address from the FIFO head.
//  Latches each 35-bit glyph and streams it one 7-bit column at a time, over a valid/ready
//  handshake, to the downstream pixel/WS2812B framing logic.
// PARAMETERS
//  FIFO_DEPTH  4   character FIFO entries; power of 2, >=2
//  CHAR_W      7   ASCII code width; equals ROM address width
//  GLYPH_W     35  ROM data width: 5 columns x 7 rows
// PORTS
//  clk         in   1                  single system clock
//  rst         in   1                  synchronous reset, active-high
//  char_in     in   CHAR_W             ASCII code to enqueue
//  char_valid  in   1                  char_in valid
//  char_ready  out  1                  FIFO can accept; equals !full
//  flush       in   1                  synchronous clear of FIFO and current glyph
//  rom_addr    out  CHAR_W             ROM address; combinational from FIFO head (0 when empty)
//  rom_data    in   GLYPH_W            ROM data; combinational response to rom_addr
//  col_out     out  7                  column pixels; bit r = row r (row 0 = top)
//  col_valid   out  1                  col_out valid
//  col_ready   in   1                  downstream accepts column
//  col_last    out  1                  current column is the final column of the glyph
//  busy        out  1                  glyph in flight or FIFO non-empty
//  fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries
// BEHAVIOUR
//  - Reset (and flush): FIFO empty, fifo_count=0, state IDLE. col_valid=0, col_out=0,
//    col_last=0, busy=0, char_ready=1. Takes effect on the same edge; an in-flight glyph is
//    dropped with no further columns. rst has priority over flush; flush has priority over push.
//  - Push: char_valid && char_ready at an edge writes char_in at the tail.
//  - Pop: occurs when a new glyph is loaded.
//  - Push and pop on the same edge: fifo_count is unchanged. When full, char_ready=0 even if
//    a pop occurs that edge (no pass-through).
//  - Pointers wrap modulo FIFO_DEPTH.
//  - Column map: column c (0..4, 0 = leftmost) = rom_data[(4-c)*7 +: 7].
//  - States:
//    - IDLE: col_valid=0. If FIFO is non-empty at an edge: glyph_reg<=rom_data, pop,
//      col_idx<=0, go to EMIT.
//    - EMIT: col_valid=1, col_out=column col_idx of glyph_reg. col_out and col_last are held
//      stable while col_valid && !col_ready. On handshake with col_idx<4: col_idx++. On
//      handshake with col_idx==4: go to SPACE (macro defined) else go to END.
//    - SPACE: col_valid=1, col_out=7'h00, col_last=1. On handshake go to END.
//    - END is not a registered state; it is the resolution of the final handshake:
//      - FIFO non-empty: load the next glyph on the same edge and stay in EMIT with col_idx=0.
//        There is no bubble between characters.
//      - FIFO empty: go to IDLE.
//  - col_last:
//    - Macro defined: col_last=1 only in SPACE.
//    - Macro undefined: col_last=1 in EMIT with col_idx==4.
//  - Latency: char accepted at edge E0 into an empty FIFO in IDLE. The glyph latches at E1,
//    and col_valid is high after E1. Push-to-first-column is 1 cycle.
//  - Codes <32 are passed to the ROM unchanged. The ROM returns all-ones, so the glyph is a
//    solid block.
//  - busy = (state!=IDLE) || (fifo_count!=0).
// CONFIGURATION
//  - GLYPH_SPACER_EN:
//    - Defined: 6 columns per character; a blank column follows column 4 and carries col_last.
//    - Undefined: 5 columns per character; no SPACE state; column 4 carries col_last.
// TESTING (ROM modelled by the bench; GLYPH_SPACER_EN defined unless noted)
//  1. Reset, then push 'A' (7'h41), col_ready=1 -> rom_addr=7'h41 after E0. Columns 0..4 equal
//     ROM('A') slices in 5 consecutive cycles, then 7'h00 with col_last=1. Then IDLE, busy=0.
//  2. Push "HI" back-to-back, col_ready=1 -> 12 columns in 12 consecutive cycles with no gap.
//     col_last is seen at columns 6 and 12.
//  3. Hold col_ready=0 for 3 cycles mid-glyph at col_idx=2 -> col_out and col_last are stable
//     and col_valid=1 throughout. Column 3 follows the release.
//  4. col_ready=0 and push 5 chars with FIFO_DEPTH=4 -> 4 pushes plus 1 loaded glyph are
//     accepted. The next char_valid sees char_ready=0 and fifo_count=4. A simultaneous
//     push/pop when full is refused.
//  5. Assert flush (or rst) mid-glyph with 2 chars queued -> the next cycle has col_valid=0,
//     fifo_count=0, busy=0. A subsequent push of 7'h20 emits 6 zero columns.
//  6. GLYPH_SPACER_EN undefined; push 7'h05 -> 5 columns of 7'h7F. col_last=1 on column 4,
//     and no spacer column follows.

Source files
------------

// File: rtl/glyph_column_sequencer.sv
// Character FIFO plus column sequencer for the 5x7 LED-matrix glyph ROM.
// Optional blank spacer column after each glyph: define GLYPH_SPACER_EN.
module glyph_column_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CHAR_W     = 7,
  parameter int GLYPH_W    = 35
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CHAR_W-1:0]                 char_in,
  input  logic                              char_valid,
  output logic                              char_ready,
  input  logic                              flush,
  output logic [CHAR_W-1:0]                 rom_addr,
  input  logic [GLYPH_W-1:0]                rom_data,
  output logic [6:0]                        col_out,
  output logic                              col_valid,
  input  logic                              col_ready,
  output logic                              col_last,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  state_t              state;
  logic [CHAR_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic [GLYPH_W-1:0]  glyph_reg;
  logic [2:0]          col_idx;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic col_hs;
  logic final_hs;

  // Column c of a glyph; column 0 (leftmost) sits in the top 7 bits.
  function automatic logic [6:0] glyph_col(input logic [GLYPH_W-1:0] g, input logic [2:0] idx);
    logic [6:0] col;
    case (idx)
      3'd0:    col = g[34:28];
      3'd1:    col = g[27:21];
      3'd2:    col = g[20:14];
      3'd3:    col = g[13:7];
      3'd4:    col = g[6:0];
      default: col = 7'h00;
    endcase
    return col;
  endfunction

  assign fifo_empty = (count == {CNT_W{1'b0}});
  assign fifo_full  = (count == FULL_COUNT);
  assign char_ready = !fifo_full;
  assign fifo_count = count;
  assign rom_addr   = fifo_empty ? {CHAR_W{1'b0}} : fifo_mem[rd_ptr];
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  assign push   = char_valid && !fifo_full;
  assign col_hs = col_valid && col_ready;

`ifdef GLYPH_SPACER_EN
  assign final_hs = (state == ST_SPACE) && col_hs;
`else
  assign final_hs = (state == ST_EMIT) && col_hs && (col_idx == 3'd4);
`endif

  // A glyph is loaded from the head either from IDLE or straight after the final column.
  assign pop = !fifo_empty && ((state == ST_IDLE) || final_hs);

  // Character storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      fifo_mem[wr_ptr] <= char_in;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Column sequencer with registered column outputs.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= ST_IDLE;
      glyph_reg <= {GLYPH_W{1'b0}};
      col_idx   <= 3'd0;
      col_out   <= 7'h00;
      col_valid <= 1'b0;
      col_last  <= 1'b0;
    end else if (pop) begin
      state     <= ST_EMIT;
      glyph_reg <= rom_data;
      col_idx   <= 3'd0;
      col_out   <= glyph_col(rom_data, 3'd0);
      col_valid <= 1'b1;
      col_last  <= 1'b0;
    end else if (final_hs) begin
      state     <= ST_IDLE;
      col_idx   <= 3'd0;
      col_out   <= 7'h00;
      col_valid <= 1'b0;
      col_last  <= 1'b0;
    end else begin
      case (state)
        ST_EMIT: begin
          if (col_hs && (col_idx != 3'd4)) begin
            col_idx <= col_idx + 3'd1;
            col_out <= glyph_col(glyph_reg, col_idx + 3'd1);
`ifdef GLYPH_SPACER_EN
            col_last <= 1'b0;
`else
            col_last <= (col_idx == 3'd3);
`endif
          end
`ifdef GLYPH_SPACER_EN
          else if (col_hs) begin
            state    <= ST_SPACE;
            col_out  <= 7'h00;
            col_last <= 1'b1;
          end
`endif
          else begin
            col_idx <= col_idx;
          end
        end
        ST_SPACE: begin
          col_out <= 7'h00;
        end
        ST_IDLE: begin
          col_valid <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          col_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_column_sequencer.sv
// Directed self-checking bench for glyph_column_sequencer with a behavioural glyph ROM.
module tb_glyph_column_sequencer;

`ifdef GLYPH_SPACER_EN
  localparam int NCOL = 6;
`else
  localparam int NCOL = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        flush;
  logic [6:0]  rom_addr;
  logic [34:0] rom_data;
  logic [6:0]  col_out;
  logic        col_valid;
  logic        col_ready;
  logic        col_last;
  logic        busy;
  logic [2:0]  fifo_count;

  int checks = 0;
  int passed = 0;

  glyph_column_sequencer dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .flush(flush), .rom_addr(rom_addr), .rom_data(rom_data),
    .col_out(col_out), .col_valid(col_valid), .col_ready(col_ready), .col_last(col_last),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] rom_model(input logic [6:0] a);
    if (a < 7'd32) return {35{1'b1}};
    if (a == 7'h20) return 35'd0;
    return {a, a ^ 7'h55, ~a, a + 7'd3, a ^ 7'h2A};
  endfunction

  always_comb rom_data = rom_model(rom_addr);

  function automatic logic [6:0] exp_col(input logic [6:0] code, input int c);
    logic [34:0] g;
    g = rom_model(code);
    if (c >= 5) return 7'h00;
    return g[(4-c)*7 +: 7];
  endfunction

  function automatic logic exp_last(input int c);
    return (c == NCOL - 1) ? 1'b1 : 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; char_valid = 1'b0; char_in = 7'h00; col_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (col_valid !== 1'b0) $display("FAIL reset_col_valid got %b want 0", col_valid); else passed++;
    checks++; if (col_out !== 7'h00) $display("FAIL reset_col_out got %h want 00", col_out); else passed++;
    checks++; if (col_last !== 1'b0) $display("FAIL reset_col_last got %b want 0", col_last); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (char_ready !== 1'b1) $display("FAIL reset_char_ready got %b want 1", char_ready); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL reset_fifo_count got %0d want 0", fifo_count); else passed++;
    checks++; if (rom_addr !== 7'h00) $display("FAIL reset_rom_addr got %h want 00", rom_addr); else passed++;
  endtask

  task automatic test_single_glyph(input logic [6:0] code, input string name);
    do_reset();
    col_ready = 1'b1; char_in = code; char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    checks++; if (rom_addr !== code) $display("FAIL %s_rom_addr got %h want %h", name, rom_addr, code); else passed++;
    checks++; if (fifo_count !== 3'd1) $display("FAIL %s_count got %0d want 1", name, fifo_count); else passed++;
    checks++; if (col_valid !== 1'b0) $display("FAIL %s_pre_valid got %b want 0", name, col_valid); else passed++;
    @(negedge clk);
    for (int c = 0; c < NCOL; c++) begin
      checks++; if (col_valid !== 1'b1) $display("FAIL %s_valid col %0d got %b want 1", name, c, col_valid); else passed++;
      checks++; if (col_out !== exp_col(code, c)) $display("FAIL %s_col %0d got %h want %h", name, c, col_out, exp_col(code, c)); else passed++;
      checks++; if (col_last !== exp_last(c)) $display("FAIL %s_last col %0d got %b want %b", name, c, col_last, exp_last(c)); else passed++;
      @(negedge clk);
    end
    checks++; if (col_valid !== 1'b0) $display("FAIL %s_end_valid got %b want 0", name, col_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL %s_end_busy got %b want 0", name, busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] code;
    do_reset();
    col_ready = 1'b1; char_in = 7'h48; char_valid = 1'b1;
    @(negedge clk);
    char_in = 7'h49;
    @(negedge clk);
    char_valid = 1'b0;
    for (int k = 0; k < 2*NCOL; k++) begin
      code = (k < NCOL) ? 7'h48 : 7'h49;
      checks++; if (col_valid !== 1'b1) $display("FAIL b2b_valid step %0d got %b want 1", k, col_valid); else passed++;
      checks++; if (col_out !== exp_col(code, k % NCOL)) $display("FAIL b2b_col step %0d got %h want %h", k, col_out, exp_col(code, k % NCOL)); else passed++;
      checks++; if (col_last !== exp_last(k % NCOL)) $display("FAIL b2b_last step %0d got %b want %b", k, col_last, exp_last(k % NCOL)); else passed++;
      @(negedge clk);
    end
    checks++; if (col_valid !== 1'b0) $display("FAIL b2b_end_valid got %b want 0", col_valid); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    col_ready = 1'b1; char_in = 7'h4D; char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      checks++; if (col_out !== exp_col(7'h4D, c)) $display("FAIL stall_pre col %0d got %h want %h", c, col_out, exp_col(7'h4D, c)); else passed++;
      @(negedge clk);
    end
    col_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (col_valid !== 1'b1) $display("FAIL stall_valid cycle %0d got %b want 1", i, col_valid); else passed++;
      checks++; if (col_out !== exp_col(7'h4D, 2)) $display("FAIL stall_col cycle %0d got %h want %h", i, col_out, exp_col(7'h4D, 2)); else passed++;
      checks++; if (col_last !== 1'b0) $display("FAIL stall_last cycle %0d got %b want 0", i, col_last); else passed++;
      if (i < 3) @(negedge clk);
    end
    col_ready = 1'b1;
    @(negedge clk);
    for (int c = 3; c < NCOL; c++) begin
      checks++; if (col_out !== exp_col(7'h4D, c)) $display("FAIL stall_post col %0d got %h want %h", c, col_out, exp_col(7'h4D, c)); else passed++;
      checks++; if (col_last !== exp_last(c)) $display("FAIL stall_post_last col %0d got %b want %b", c, col_last, exp_last(c)); else passed++;
      @(negedge clk);
    end
    checks++; if (col_valid !== 1'b0) $display("FAIL stall_end_valid got %b want 0", col_valid); else passed++;
  endtask

  task automatic test_fifo_full();
    do_reset();
    col_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      char_in = 7'h50 + 7'(i); char_valid = 1'b1;
      @(negedge clk);
    end
    checks++; if (char_ready !== 1'b0) $display("FAIL full_char_ready got %b want 0", char_ready); else passed++;
    checks++; if (fifo_count !== 3'd4) $display("FAIL full_count got %0d want 4", fifo_count); else passed++;
    checks++; if (rom_addr !== 7'h51) $display("FAIL full_rom_addr got %h want 51", rom_addr); else passed++;
    checks++; if (col_out !== exp_col(7'h50, 0)) $display("FAIL full_col0 got %h want %h", col_out, exp_col(7'h50, 0)); else passed++;
    char_in = 7'h55;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd4) $display("FAIL full_refused_count got %0d want 4", fifo_count); else passed++;
    col_ready = 1'b1;
    for (int c = 0; c < NCOL; c++) begin
      checks++; if (col_out !== exp_col(7'h50, c)) $display("FAIL full_stream col %0d got %h want %h", c, col_out, exp_col(7'h50, c)); else passed++;
      @(negedge clk);
    end
    char_valid = 1'b0;
    checks++; if (fifo_count !== 3'd3) $display("FAIL full_pushpop_count got %0d want 3", fifo_count); else passed++;
    checks++; if (rom_addr !== 7'h52) $display("FAIL full_next_head got %h want 52", rom_addr); else passed++;
    checks++; if (col_out !== exp_col(7'h51, 0)) $display("FAIL full_next_col0 got %h want %h", col_out, exp_col(7'h51, 0)); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    col_ready = 1'b1; char_in = 7'h60; char_valid = 1'b1;
    @(negedge clk);
    char_in = 7'h61;
    @(negedge clk);
    char_in = 7'h62;
    @(negedge clk);
    char_valid = 1'b0;
    checks++; if (fifo_count !== 3'd2) $display("FAIL flush_pre_count got %0d want 2", fifo_count); else passed++;
    checks++; if (col_out !== exp_col(7'h60, 1)) $display("FAIL flush_pre_col got %h want %h", col_out, exp_col(7'h60, 1)); else passed++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (col_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", col_valid); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL flush_count got %0d want 0", fifo_count); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else passed++;
    checks++; if (col_out !== 7'h00) $display("FAIL flush_col_out got %h want 00", col_out); else passed++;
    checks++; if (char_ready !== 1'b1) $display("FAIL flush_char_ready got %b want 1", char_ready); else passed++;
    char_in = 7'h20; char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NCOL; c++) begin
      checks++; if (col_valid !== 1'b1) $display("FAIL space_valid col %0d got %b want 1", c, col_valid); else passed++;
      checks++; if (col_out !== 7'h00) $display("FAIL space_col %0d got %h want 00", c, col_out); else passed++;
      checks++; if (col_last !== exp_last(c)) $display("FAIL space_last col %0d got %b want %b", c, col_last, exp_last(c)); else passed++;
      @(negedge clk);
    end
    checks++; if (col_valid !== 1'b0) $display("FAIL space_end_valid got %b want 0", col_valid); else passed++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; char_valid = 1'b0; char_in = 7'h00; col_ready = 1'b0;
    test_reset();
    test_single_glyph(7'h41, "glyph_A");
    test_back_to_back();
    test_stall();
    test_fifo_full();
    test_flush();
    test_single_glyph(7'h05, "ctrl_05");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
